// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// It resolves three hazards and drives the pipeline-register load and flush
// controls:
//   - load-use stalls
//   - taken-branch squashes
//   - variable-latency data-memory waits, bounded by a watchdog
// A saturating counter records every cycle in which the PC is held.
module pipe_hazard_ctrl #(
   parameter int MAX_WAIT = 16,
   parameter int WCW      = 5,
   parameter int SCW      = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [4:0]     id_rs1,
   input  logic [4:0]     id_rs2,
   input  logic           id_use_rs1,
   input  logic           id_use_rs2,
   input  logic           ex_mem_read,
   input  logic [4:0]     ex_rd,
   input  logic           branch_taken,
   input  logic           mem_req,
   input  logic           mem_ready,
   input  logic           stall_clr,
   output logic           pc_load,
   output logic           ifid_load,
   output logic           idex_load,
   output logic           exmem_load,
   output logic           memwb_load,
   output logic           ifid_flush,
   output logic           idex_flush,
   output logic           exmem_flush,
   output logic           mem_busy,
   output logic           mem_abort,
   output logic           mem_timeout,
   output logic [SCW-1:0] stall_cnt
);

   typedef enum logic {S_RUN, S_WAIT} st_t;

   st_t            st_q, st_d;
   logic [WCW-1:0] wcnt_q, wcnt_d;
   logic           tmo_q, tmo_d;
   logic [SCW-1:0] scnt_q, scnt_d;

   logic lu, wd, frz, miss;

   assign miss = mem_req & ~mem_ready;
   assign lu   = ex_mem_read & (ex_rd != 5'd0) &
                 ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
   // Once the watchdog limit is reached, the outstanding miss no longer
   // freezes the pipe. That cycle becomes a forced release.
   assign wd   = (st_q == S_WAIT) & (wcnt_q == WCW'(MAX_WAIT));
   assign frz  = miss & ~wd;

   // Pipeline control outputs. Priority: freeze > branch > load-use > normal.
   // Every output is held low while reset is asserted.
   always_comb begin
      pc_load     = 1'b0;
      ifid_load   = 1'b0;
      idex_load   = 1'b0;
      exmem_load  = 1'b0;
      memwb_load  = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      mem_busy    = 1'b0;
      mem_abort   = 1'b0;
      if (rst) begin
         mem_abort = miss & wd;
         if (frz) begin
            mem_busy = 1'b1;
         end else if (branch_taken) begin
            // The stalled ID instruction is squashed anyway, so lu is ignored here.
            {pc_load, ifid_load, idex_load, exmem_load, memwb_load} = 5'b11111;
            {ifid_flush, idex_flush, exmem_flush}                   = 3'b111;
         end else if (lu) begin
            {pc_load, ifid_load, idex_load, exmem_load, memwb_load} = 5'b00111;
            idex_flush = 1'b1;
         end else begin
            {pc_load, ifid_load, idex_load, exmem_load, memwb_load} = 5'b11111;
         end
      end
   end

   // Memory-wait FSM, watchdog counter, sticky timeout flag and stall counter.
   always_comb begin
      st_d   = st_q;
      wcnt_d = wcnt_q;
      tmo_d  = tmo_q;
      scnt_d = scnt_q;
      case (st_q)
         S_RUN: begin
            if (miss) begin
               st_d   = S_WAIT;
               wcnt_d = WCW'(1);
            end else begin
               wcnt_d = '0;
            end
         end
         S_WAIT: begin
            // If mem_req drops while waiting, treat it as completion.
            if (!miss) begin
               st_d   = S_RUN;
               wcnt_d = '0;
            end else if (wd) begin
               st_d   = S_RUN;
               wcnt_d = '0;
               tmo_d  = 1'b1;
            end else begin
               wcnt_d = wcnt_q + WCW'(1);
            end
         end
         default: begin
            st_d   = S_RUN;
            wcnt_d = '0;
         end
      endcase
      if (stall_clr)
         scnt_d = '0;
      else if (!pc_load && !(&scnt_q))
         scnt_d = scnt_q + SCW'(1);
   end

   // State registers. An asynchronous reset abandons any wait in progress.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q   <= S_RUN;
         wcnt_q <= '0;
         tmo_q  <= 1'b0;
         scnt_q <= '0;
      end else begin
         st_q   <= st_d;
         wcnt_q <= wcnt_d;
         tmo_q  <= tmo_d;
         scnt_q <= scnt_d;
      end
   end

   assign mem_timeout = tmo_q;
   assign stall_cnt   = scnt_q;

endmodule
